reset_sequencer: RTL and testbench

- Sequences bring-up and reset of the P1V core on FPGA boards.
- Holds the core in reset until the PLL reports lock and has stayed locked for a programmable settle time.
- Merges the board reset button and the host serial RTS line into one clean, minimum-width reset pulse.
- Reports the cause of the last reset.
- Sits between the clock generator and `p1v`; its `res` output drives `p1v.inp_resn` through an inverter.

---
 rtl/reset_sequencer.sv | 175 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Bring-up/reset sequencer for the P1V core: PLL lock qualification, button/RTS merge, reset cause. Optional RTS_EDGE mode: RESET_SEQ_RTS_EDGE_EN.
// Latency: RTS/lock loss SYNC_STAGES+1 cycles to res, button SYNC_STAGES+DEBOUNCE+1; power-up release LOCK_WAIT cycles after STABLE entry.
// No backpressure: all inputs are level/asynchronous, outputs are registered levels.
module reset_sequencer #(
  parameter int LOCK_WAIT   = 1024,
  parameter int MIN_PULSE   = 16384,
  parameter int DEBOUNCE    = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock_160,
  input  logic       inp_resn,
  input  logic       pll_locked,
  input  logic       rts,
  input  logic       reset_btn,
  output logic       res,
  output logic       clk_ok,
  output logic [1:0] cause
);

  localparam int CNT_MAX = (LOCK_WAIT > MIN_PULSE) ? LOCK_WAIT : MIN_PULSE;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam int DW      = $clog2(DEBOUNCE) + 1;

  localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_WAIT - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(MIN_PULSE - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {HOLD, STABLE, RUN, PULSE} state_t;

  logic [SYNC_STAGES-1:0] lock_sync;
  logic [SYNC_STAGES-1:0] rts_sync;
  logic [SYNC_STAGES-1:0] btn_sync;
  logic                   lock_s;
  logic                   rts_s;
  logic                   btn_s;

  // Button and RTS are active-low, so their chains idle high out of reset.
  always_ff @(posedge clock_160 or negedge inp_resn) begin
    if (!inp_resn) begin
      lock_sync <= '0;
      rts_sync  <= '1;
      btn_sync  <= '1;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
      rts_sync  <= {rts_sync[SYNC_STAGES-2:0], rts};
      btn_sync  <= {btn_sync[SYNC_STAGES-2:0], reset_btn};
    end
  end

  assign lock_s = lock_sync[SYNC_STAGES-1];
  assign rts_s  = rts_sync[SYNC_STAGES-1];
  assign btn_s  = btn_sync[SYNC_STAGES-1];

  logic [DW-1:0] db_cnt;
  logic          btn_pressed;

  // A sample is contrary when its level matches btn_pressed (pin low = pressed).
  always_ff @(posedge clock_160 or negedge inp_resn) begin
    if (!inp_resn) begin
      db_cnt      <= '0;
      btn_pressed <= 1'b0;
    end else if (btn_s == btn_pressed) begin
      if (db_cnt == DB_LAST) begin
        btn_pressed <= ~btn_pressed;
        db_cnt      <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  logic rts_req;
  logic rts_retrig;

`ifdef RESET_SEQ_RTS_EDGE_EN
  logic rts_d;

  always_ff @(posedge clock_160 or negedge inp_resn) begin
    if (!inp_resn) rts_d <= 1'b1;
    else           rts_d <= rts_s;
  end

  assign rts_req    = rts_d & ~rts_s;
  assign rts_retrig = rts_req;
`else
  assign rts_req    = ~rts_s;
  assign rts_retrig = 1'b0;
`endif

  logic       any_req;
  logic [1:0] req_cause;

  assign any_req   = btn_pressed | rts_req;
  assign req_cause = btn_pressed ? 2'd1 : 2'd2;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  // res/clk_ok are assigned alongside each transition so they track the next state.
  always_ff @(posedge clock_160 or negedge inp_resn) begin
    if (!inp_resn) begin
      state  <= HOLD;
      cnt    <= '0;
      res    <= 1'b1;
      clk_ok <= 1'b0;
      cause  <= 2'd0;
    end else begin
      cnt <= cnt_inc;
      case (state)
        HOLD: begin
          if (lock_s) begin
            state <= STABLE;
            cnt   <= '0;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state <= HOLD;
            cnt   <= '0;
          end else if (cnt == LOCK_LAST) begin
            cnt    <= '0;
            clk_ok <= 1'b1;
            if (any_req) begin
              state <= PULSE;
              cause <= req_cause;
            end else begin
              state <= RUN;
              res   <= 1'b0;
            end
          end
        end
        RUN: begin
          if (!lock_s) begin
            state  <= HOLD;
            cnt    <= '0;
            res    <= 1'b1;
            clk_ok <= 1'b0;
            cause  <= 2'd0;
          end else if (any_req) begin
            state <= PULSE;
            cnt   <= '0;
            res   <= 1'b1;
            cause <= req_cause;
          end
        end
        PULSE: begin
          if (!lock_s) begin
            state  <= HOLD;
            cnt    <= '0;
            clk_ok <= 1'b0;
            cause  <= 2'd0;
          end else if (rts_retrig) begin
            cnt <= '0;
          end else if (cnt >= PULSE_LAST && !any_req) begin
            state <= RUN;
            cnt   <= '0;
            res   <= 1'b0;
          end
        end
        default: begin
          state  <= HOLD;
          cnt    <= '0;
          res    <= 1'b1;
          clk_ok <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: expected cycle stamps/widths are queued when stimulus is driven and popped when res moves.
module tb_reset_sequencer;

  logic       clock_160 = 1'b0;
  logic       inp_resn;
  logic       pll_locked;
  logic       rts;
  logic       reset_btn;
  logic       res;
  logic       clk_ok;
  logic [1:0] cause;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string  tag;
    integer val;
  } exp_t;

  exp_t exp_q[$];

  reset_sequencer #(
    .LOCK_WAIT  (8),
    .MIN_PULSE  (16),
    .DEBOUNCE   (4),
    .SYNC_STAGES(2)
  ) dut (
    .clock_160 (clock_160),
    .inp_resn  (inp_resn),
    .pll_locked(pll_locked),
    .rts       (rts),
    .reset_btn (reset_btn),
    .res       (res),
    .clk_ok    (clk_ok),
    .cause     (cause)
  );

  always #5 clock_160 = ~clock_160;

  always @(posedge clock_160) cyc <= cyc + 1;

  task automatic expect_val(input string tag, input integer val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic check(input integer obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      e.tag = "empty_scoreboard";
      e.val = -999;
    end else begin
      e = exp_q.pop_front();
    end
    n_cmp++;
    assert (obs === e.val) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock_160);
  endtask

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge clock_160);
  endtask

  // Returns the cycle at which res first shows val, or -1 if the budget expires.
  task automatic wait_res(input logic val, input int budget, output integer at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock_160);
      if (res === val) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    integer t, r, f, hits;
    inp_resn   = 1'b0;
    pll_locked = 1'b0;
    rts        = 1'b1;
    reset_btn  = 1'b1;

    // Reset state
    step(5);
    expect_val("rst_res", 1);      check(res);
    expect_val("rst_clk_ok", 0);   check(clk_ok);
    expect_val("rst_cause", 0);    check(cause);
    inp_resn = 1'b1;

    // Power-up: lock at cycle 20, release 2+1+8 later
    at_cyc(20);
    pll_locked = 1'b1;
    t = cyc;
    expect_val("pwrup_release", t + 11);
    wait_res(1'b0, 60, r);         check(r);
    expect_val("pwrup_clk_ok", 1); check(clk_ok);
    expect_val("pwrup_cause", 0);  check(cause);

    // Lock loss in RUN
    step(5);
    pll_locked = 1'b0;
    t = cyc;
    expect_val("lockloss_latency", t + 3);
    wait_res(1'b1, 20, r);         check(r);
    expect_val("lockloss_clk_ok", 0); check(clk_ok);
    expect_val("lockloss_cause", 0);  check(cause);

    // One-cycle glitch mid-STABLE restarts the lock wait
    step(3);
    pll_locked = 1'b1;
    step(5);
    pll_locked = 1'b0;
    t = cyc;
    step(1);
    pll_locked = 1'b1;
    expect_val("glitch_release", t + 12);
    wait_res(1'b0, 60, r);         check(r);

`ifdef RESET_SEQ_RTS_EDGE_EN
    // Held RTS gives a single 16-cycle pulse
    step(5);
    rts = 1'b0;
    t = cyc;
    expect_val("rts_edge_rise", t + 3);
    wait_res(1'b1, 20, r);         check(r);
    expect_val("rts_edge_cause", 2); check(cause);
    expect_val("rts_edge_width", 16);
    wait_res(1'b0, 60, f);         check(f - r);
    at_cyc(t + 100);
    rts = 1'b1;

    // Second edge seen at pulse cycle 10 adds 16 from there
    step(5);
    rts = 1'b0;
    t = cyc;
    wait_res(1'b1, 20, r);
    expect_val("rts_retrig_rise", t + 3); check(r);
    at_cyc(t + 5);
    rts = 1'b1;
    at_cyc(r + 7);
    rts = 1'b0;
    expect_val("rts_retrig_width", 26);
    wait_res(1'b0, 60, f);         check(f - r);
    step(2);
    rts = 1'b1;
`else
    // Long RTS hold: release one cycle after synchronized RTS returns high
    step(5);
    rts = 1'b0;
    t = cyc;
    expect_val("rts_lvl_rise", t + 3);
    wait_res(1'b1, 20, r);         check(r);
    expect_val("rts_lvl_cause", 2); check(cause);
    at_cyc(t + 40);
    rts = 1'b1;
    expect_val("rts_lvl_fall", t + 43);
    wait_res(1'b0, 60, f);         check(f);

    // Short RTS: minimum width
    step(5);
    rts = 1'b0;
    t = cyc;
    wait_res(1'b1, 20, r);
    expect_val("rts_short_rise", t + 3); check(r);
    at_cyc(t + 5);
    rts = 1'b1;
    expect_val("rts_short_width", 16);
    wait_res(1'b0, 60, f);         check(f - r);
`endif

    // Bouncing button never debounces
    step(5);
    hits = 0;
    for (int i = 0; i < 30; i++) begin
      if (i < 20) reset_btn = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      else        reset_btn = 1'b1;
      @(negedge clock_160);
      if (res !== 1'b0) hits = hits + 1;
    end
    expect_val("bounce_no_reset", 0); check(hits);

    // Clean 4-cycle press
    step(2);
    reset_btn = 1'b0;
    t = cyc;
    expect_val("btn_rise", t + 7);
    at_cyc(t + 4);
    reset_btn = 1'b1;
    wait_res(1'b1, 20, r);         check(r);
    expect_val("btn_cause", 1);    check(cause);
    expect_val("btn_width", 16);
    wait_res(1'b0, 60, f);         check(f - r);

    // Button and lock loss reach the FSM together: lock loss wins
    step(5);
    reset_btn = 1'b0;
    t = cyc;
    at_cyc(t + 4);
    pll_locked = 1'b0;
    expect_val("prio_lock_rise", t + 7);
    wait_res(1'b1, 20, r);         check(r);
    expect_val("prio_lock_cause", 0);  check(cause);
    expect_val("prio_lock_clk_ok", 0); check(clk_ok);
    at_cyc(t + 8);
    reset_btn = 1'b1;
    at_cyc(t + 12);
    pll_locked = 1'b1;
    expect_val("prio_lock_release", cyc + 11);
    wait_res(1'b0, 60, f);         check(f);

    // Button and RTS together in RUN: button wins
    step(5);
    reset_btn = 1'b0;
    t = cyc;
    at_cyc(t + 4);
    rts = 1'b0;
    expect_val("prio_btn_rise", t + 7);
    wait_res(1'b1, 20, r);         check(r);
    expect_val("prio_btn_cause", 1); check(cause);
    at_cyc(t + 8);
    reset_btn = 1'b1;
    rts = 1'b1;

    // inp_resn mid-PULSE clears state asynchronously
    at_cyc(t + 12);
    inp_resn = 1'b0;
    #1;
    expect_val("async_res", 1);    check(res);
    expect_val("async_clk_ok", 0); check(clk_ok);
    expect_val("async_cause", 0);  check(cause);
    step(2);
    inp_resn = 1'b1;
    expect_val("post_rst_release", cyc + 11);
    wait_res(1'b0, 60, f);         check(f);
    expect_val("post_rst_cause", 0);  check(cause);
    expect_val("post_rst_clk_ok", 1); check(clk_ok);

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
